// File: rtl/plic_gateway.sv
// plic_gateway: per-source interrupt gateway ahead of the PLIC priority tree.
// Synchronises raw sources and tracks each one through pending/claim/complete.
module plic_gateway #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_CNT_W  = 2,
  parameter int ID_W        = 3
) (
  input  logic               pclk,
  input  logic               preset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] trig_mode,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic               claim_valid,
  input  logic [ID_W-1:0]    claim_id,
  input  logic               complete_valid,
  input  logic [ID_W-1:0]    complete_id,
  output logic [NUM_SRC-1:0] irq_req,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_SERV = 2'd2
  } state_e;

  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] sync_dly_q;
  logic [NUM_SRC-1:0] sync;
  logic [NUM_SRC-1:0] rise;

  state_e                state_q [NUM_SRC];
  state_e                state_d [NUM_SRC];
  logic [EDGE_CNT_W-1:0] cnt_q   [NUM_SRC];
  logic [EDGE_CNT_W-1:0] cnt_d   [NUM_SRC];

  logic [NUM_SRC-1:0] claim_hit;
  logic [NUM_SRC-1:0] comp_hit;
  logic [NUM_SRC-1:0] edge_hit;
  logic [NUM_SRC-1:0] cnt_dec;
  logic [NUM_SRC-1:0] cnt_nz;

  logic [NUM_SRC-1:0] irq_req_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] serv_q;

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~sync_dly_q;

  // A same-id claim masks the complete so a serviced source stays put.
  always_comb begin
    claim_hit = '0;
    comp_hit  = '0;
    edge_hit  = '0;
    cnt_dec   = '0;
    cnt_nz    = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      claim_hit[n] = claim_valid && (claim_id == ID_W'(n));
      comp_hit[n]  = complete_valid && (complete_id == ID_W'(n))
                     && !(claim_valid && (claim_id == ID_W'(n)));
      edge_hit[n]  = trig_mode[n] && rise[n] && (state_q[n] != S_IDLE);
      cnt_dec[n]   = trig_mode[n] && comp_hit[n] && (state_q[n] == S_SERV);
      cnt_nz[n]    = (cnt_q[n] != '0);
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_SRC; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n];
      case (state_q[n])
        S_IDLE: begin
          if (trig_mode[n] ? rise[n] : sync[n]) state_d[n] = S_PEND;
        end
        S_PEND: begin
          if (claim_hit[n]) state_d[n] = S_SERV;
          else if (!trig_mode[n] && !sync[n]) state_d[n] = S_IDLE;
        end
        S_SERV: begin
          if (comp_hit[n]) begin
            if (trig_mode[n] && (cnt_nz[n] || rise[n])) state_d[n] = S_PEND;
            else state_d[n] = S_IDLE;
          end
        end
        default: state_d[n] = S_IDLE;
      endcase
      // A rise coinciding with completion is consumed as the re-pend itself.
      unique case (1'b1)
        !trig_mode[n]: cnt_d[n] = '0;
        edge_hit[n] && !cnt_dec[n]: begin
          if (cnt_q[n] != CNT_MAX) cnt_d[n] = cnt_q[n] + EDGE_CNT_W'(1);
        end
        cnt_dec[n] && !edge_hit[n] && cnt_nz[n]:
          cnt_d[n] = cnt_q[n] - EDGE_CNT_W'(1);
        default: cnt_d[n] = cnt_q[n];
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      sync_q     <= '0;
      sync_dly_q <= '0;
      irq_req_q  <= '0;
      pend_q     <= '0;
      serv_q     <= '0;
      for (int n = 0; n < NUM_SRC; n++) begin
        state_q[n] <= S_IDLE;
        cnt_q[n]   <= '0;
      end
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], irq_src};
      sync_dly_q <= sync;
      for (int n = 0; n < NUM_SRC; n++) begin
        state_q[n]   <= state_d[n];
        cnt_q[n]     <= cnt_d[n];
        pend_q[n]    <= (state_q[n] == S_PEND);
        irq_req_q[n] <= (state_q[n] == S_PEND) && irq_en[n];
        serv_q[n]    <= (state_q[n] == S_SERV);
      end
    end
  end

  assign irq_req    = irq_req_q;
  assign pending    = pend_q;
  assign in_service = serv_q;

endmodule

// File: tb/tb_plic_gateway.sv
// tb_plic_gateway: table-driven scenarios for the PLIC gateway.
// Expected outputs are queued as each row is driven and popped after its edge.
module tb_plic_gateway;

  logic       pclk;
  logic       preset_n;
  logic [7:0] irq_src;
  logic [7:0] trig_mode;
  logic [7:0] irq_en;
  logic       claim_valid;
  logic [2:0] claim_id;
  logic       complete_valid;
  logic [2:0] complete_id;
  logic [7:0] irq_req;
  logic [7:0] pending;
  logic [7:0] in_service;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] src;
    logic [7:0] en;
    logic       cv;
    logic [2:0] cid;
    logic       pv;
    logic [2:0] pid;
    logic [7:0] irq;
    logic [7:0] pend;
    logic [7:0] svc;
  } row_t;

  typedef struct {
    string      name;
    int         idx;
    logic [7:0] irq;
    logic [7:0] pend;
    logic [7:0] svc;
  } exp_t;

  exp_t sb[$];

  plic_gateway #(
    .NUM_SRC(8),
    .SYNC_STAGES(2),
    .EDGE_CNT_W(2),
    .ID_W(3)
  ) dut (
    .pclk(pclk),
    .preset_n(preset_n),
    .irq_src(irq_src),
    .trig_mode(trig_mode),
    .irq_en(irq_en),
    .claim_valid(claim_valid),
    .claim_id(claim_id),
    .complete_valid(complete_valid),
    .complete_id(complete_id),
    .irq_req(irq_req),
    .pending(pending),
    .in_service(in_service)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic row_t mk(
    input logic [7:0] src, input logic [7:0] en,
    input logic cv, input logic [2:0] cid,
    input logic pv, input logic [2:0] pid,
    input logic [7:0] irq, input logic [7:0] pend, input logic [7:0] svc);
    row_t r;
    r.src = src; r.en = en; r.cv = cv; r.cid = cid;
    r.pv = pv; r.pid = pid; r.irq = irq; r.pend = pend; r.svc = svc;
    return r;
  endfunction

  task automatic drive(input row_t r);
    irq_src        = r.src;
    irq_en         = r.en;
    claim_valid    = r.cv;
    claim_id       = r.cid;
    complete_valid = r.pv;
    complete_id    = r.pid;
  endtask

  task automatic test_reset();
    exp_t e;
    preset_n = 1'b0;
    trig_mode = 8'hFB;
    drive(mk(8'hFF, 8'hFF, 1'b1, 3'd1, 1'b1, 3'd2, 8'h0, 8'h0, 8'h0));
    for (int i = 0; i < 6; i++) begin
      if (i == 2) drive(mk(8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 0));
      if (i == 3) preset_n = 1'b1;
      sb.push_back('{"reset", i, 8'h00, 8'h00, 8'h00});
      if (i == 0) #3; else @(negedge pclk);
      e = sb.pop_front();
      n_cmp++;
      if ({irq_req, pending, in_service} !== {e.irq, e.pend, e.svc}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got irq=%h pend=%h svc=%h want irq=%h pend=%h svc=%h",
                 e.name, e.idx, irq_req, pending, in_service, e.irq, e.pend, e.svc);
      end
    end
  endtask

  task automatic test_edge();
    row_t r[$];
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      r.push_back(mk((i < 7) ? 8'h02 : 8'h00, 8'hFF,
                     i == 4, 3'd1, i == 6, 3'd1,
                     (i == 3 || i == 4) ? 8'h02 : 8'h00,
                     (i == 3 || i == 4) ? 8'h02 : 8'h00,
                     (i == 5 || i == 6) ? 8'h02 : 8'h00));
    end
    foreach (r[i]) begin
      drive(r[i]);
      sb.push_back('{"edge", i, r[i].irq, r[i].pend, r[i].svc});
      @(negedge pclk);
      e = sb.pop_front();
      n_cmp++;
      if ({irq_req, pending, in_service} !== {e.irq, e.pend, e.svc}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got irq=%h pend=%h svc=%h want irq=%h pend=%h svc=%h",
                 e.name, e.idx, irq_req, pending, in_service, e.irq, e.pend, e.svc);
      end
    end
  endtask

  task automatic test_edge_queue();
    row_t r[$];
    exp_t e;
    logic [7:0] s, p, v;
    for (int i = 0; i < 32; i++) begin
      s = (i < 4 || (i >= 6 && i < 20 && ((i - 6) % 4) < 2)) ? 8'h10 : 8'h00;
      p = 8'h00;
      v = 8'h00;
      if (i == 3 || (i >= 23 && i <= 27 && (i % 2) == 1)) p = 8'h10;
      else if ((i >= 4 && i <= 22) || (i >= 24 && i <= 28)) v = 8'h10;
      r.push_back(mk(s, 8'hFF,
                     i == 3 || (i >= 23 && i <= 27 && (i % 2) == 1), 3'd4,
                     i >= 22 && i <= 28 && (i % 2) == 0, 3'd4,
                     p, p, v));
    end
    foreach (r[i]) begin
      drive(r[i]);
      sb.push_back('{"edge_queue", i, r[i].irq, r[i].pend, r[i].svc});
      @(negedge pclk);
      e = sb.pop_front();
      n_cmp++;
      if ({irq_req, pending, in_service} !== {e.irq, e.pend, e.svc}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got irq=%h pend=%h svc=%h want irq=%h pend=%h svc=%h",
                 e.name, e.idx, irq_req, pending, in_service, e.irq, e.pend, e.svc);
      end
    end
  endtask

  task automatic test_level();
    row_t r[$];
    exp_t e;
    logic [7:0] p;
    for (int i = 0; i < 16; i++) begin
      p = (i >= 3 && i <= 12) ? 8'h04 : 8'h00;
      r.push_back(mk((i < 10) ? 8'h04 : 8'h00, 8'hFF, 0, 0, 0, 0, p, p, 8'h00));
    end
    foreach (r[i]) begin
      drive(r[i]);
      sb.push_back('{"level", i, r[i].irq, r[i].pend, r[i].svc});
      @(negedge pclk);
      e = sb.pop_front();
      n_cmp++;
      if ({irq_req, pending, in_service} !== {e.irq, e.pend, e.svc}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got irq=%h pend=%h svc=%h want irq=%h pend=%h svc=%h",
                 e.name, e.idx, irq_req, pending, in_service, e.irq, e.pend, e.svc);
      end
    end
  endtask

  task automatic test_mask();
    row_t r[$];
    exp_t e;
    logic [7:0] q, p, v;
    for (int i = 0; i < 12; i++) begin
      p = (i >= 3 && i <= 7) ? 8'h40 : 8'h00;
      q = (i == 6 || i == 7) ? 8'h40 : 8'h00;
      v = (i == 8) ? 8'h40 : 8'h00;
      r.push_back(mk((i < 9) ? 8'h40 : 8'h00, (i < 6) ? 8'hBF : 8'hFF,
                     i == 7, 3'd6, i == 8, 3'd6, q, p, v));
    end
    foreach (r[i]) begin
      drive(r[i]);
      sb.push_back('{"mask", i, r[i].irq, r[i].pend, r[i].svc});
      @(negedge pclk);
      e = sb.pop_front();
      n_cmp++;
      if ({irq_req, pending, in_service} !== {e.irq, e.pend, e.svc}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got irq=%h pend=%h svc=%h want irq=%h pend=%h svc=%h",
                 e.name, e.idx, irq_req, pending, in_service, e.irq, e.pend, e.svc);
      end
    end
  endtask

  task automatic test_claim_complete();
    row_t r[$];
    exp_t e;
    r.push_back(mk(8'h09, 8'hFF, 1, 3'd5, 0, 3'd0, 8'h00, 8'h00, 8'h00));
    r.push_back(mk(8'h09, 8'hFF, 0, 3'd0, 1, 3'd2, 8'h00, 8'h00, 8'h00));
    r.push_back(mk(8'h09, 8'hFF, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 8'h00));
    r.push_back(mk(8'h09, 8'hFF, 1, 3'd3, 0, 3'd0, 8'h09, 8'h09, 8'h00));
    r.push_back(mk(8'h09, 8'hFF, 1, 3'd3, 1, 3'd3, 8'h01, 8'h01, 8'h08));
    r.push_back(mk(8'h09, 8'hFF, 1, 3'd0, 1, 3'd3, 8'h01, 8'h01, 8'h08));
    r.push_back(mk(8'h00, 8'hFF, 0, 3'd0, 1, 3'd0, 8'h00, 8'h00, 8'h01));
    r.push_back(mk(8'h00, 8'hFF, 1, 3'd5, 0, 3'd0, 8'h00, 8'h00, 8'h00));
    for (int i = 0; i < 3; i++)
      r.push_back(mk(8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    foreach (r[i]) begin
      drive(r[i]);
      sb.push_back('{"claim_complete", i, r[i].irq, r[i].pend, r[i].svc});
      @(negedge pclk);
      e = sb.pop_front();
      n_cmp++;
      if ({irq_req, pending, in_service} !== {e.irq, e.pend, e.svc}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got irq=%h pend=%h svc=%h want irq=%h pend=%h svc=%h",
                 e.name, e.idx, irq_req, pending, in_service, e.irq, e.pend, e.svc);
      end
    end
  endtask

  task automatic test_reset_mid_service();
    row_t r[$];
    exp_t e;
    logic [7:0] s;
    for (int i = 0; i < 14; i++) begin
      s = (i < 4 || i == 6 || i == 7 || i == 10 || i == 11) ? 8'h20 : 8'h00;
      r.push_back(mk(s, 8'hFF, i == 3, 3'd5, 0, 3'd0,
                     (i == 3) ? 8'h20 : 8'h00, (i == 3) ? 8'h20 : 8'h00,
                     (i >= 4) ? 8'h20 : 8'h00));
    end
    foreach (r[i]) begin
      drive(r[i]);
      sb.push_back('{"pre_reset", i, r[i].irq, r[i].pend, r[i].svc});
      @(negedge pclk);
      e = sb.pop_front();
      n_cmp++;
      if ({irq_req, pending, in_service} !== {e.irq, e.pend, e.svc}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got irq=%h pend=%h svc=%h want irq=%h pend=%h svc=%h",
                 e.name, e.idx, irq_req, pending, in_service, e.irq, e.pend, e.svc);
      end
    end
    #2 preset_n = 1'b0;
    sb.push_back('{"async_reset", 0, 8'h00, 8'h00, 8'h00});
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({irq_req, pending, in_service} !== {e.irq, e.pend, e.svc}) begin
      n_bad++;
      $display("FAIL %s[%0d]: got irq=%h pend=%h svc=%h want irq=%h pend=%h svc=%h",
               e.name, e.idx, irq_req, pending, in_service, e.irq, e.pend, e.svc);
    end
    @(negedge pclk);
    @(negedge pclk);
    preset_n = 1'b1;
    r.delete();
    for (int i = 0; i < 12; i++) begin
      r.push_back(mk((i >= 5 && i <= 8) ? 8'h20 : 8'h00, 8'hFF,
                     i == 8, 3'd5, i == 9, 3'd5,
                     (i == 8) ? 8'h20 : 8'h00, (i == 8) ? 8'h20 : 8'h00,
                     (i == 9) ? 8'h20 : 8'h00));
    end
    foreach (r[i]) begin
      drive(r[i]);
      sb.push_back('{"post_reset", i, r[i].irq, r[i].pend, r[i].svc});
      @(negedge pclk);
      e = sb.pop_front();
      n_cmp++;
      if ({irq_req, pending, in_service} !== {e.irq, e.pend, e.svc}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got irq=%h pend=%h svc=%h want irq=%h pend=%h svc=%h",
                 e.name, e.idx, irq_req, pending, in_service, e.irq, e.pend, e.svc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_edge_queue();
    test_level();
    test_mask();
    test_claim_complete();
    test_reset_mid_service();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
